// File: rtl/fill_pkg.sv
// Shared types and metadata layout helpers for the fill arbiter.
package fill_pkg;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_ISSUE = 1'b1
  } fill_state_e;

  // Metadata is {VALID, DIRTY, TAG, BLANK}, MSB first.
  function automatic int meta_valid_bit(int tag_size);
    return tag_size - 1;
  endfunction

  function automatic int meta_dirty_bit(int tag_size);
    return tag_size - 2;
  endfunction

  function automatic int blank_width(int tag_size, int tag_width);
    return tag_size - 2 - tag_width;
  endfunction

  function automatic int meta_tag_lsb(int tag_size, int tag_width);
    return blank_width(tag_size, tag_width);
  endfunction

endpackage

// File: rtl/fill_rr_arb.sv
// Two-way round-robin grant; the pointer moves past the port just accepted.
module fill_rr_arb (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_i,
  input  logic       accept_i,
  output logic [1:0] gnt_o
);

  logic ptr_q, ptr_d;

  always_comb begin
    gnt_o = 2'b01;
    if (req_i == 2'b10) begin
      gnt_o = 2'b10;
    end else if (req_i == 2'b01) begin
      gnt_o = 2'b01;
    end else if (ptr_q) begin
      gnt_o = 2'b10;
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (accept_i) ptr_d = gnt_o[0];
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= 1'b0;
    else     ptr_q <= ptr_d;
  end

endmodule

// File: rtl/fill_arbiter.sv
// Shares the AXI write port between fill and refill requesters.
// Define FILL_ARB_STAT_EN to add accept and stall counters.
module fill_arbiter
  import fill_pkg::*;
#(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 512,
  parameter int ID_WIDTH        = 4,
  parameter int TAG_SIZE        = 32,
  parameter int TAG_WIDTH       = 17,
  parameter int INDEX_WIDTH     = 9,
  parameter int OFFSET_WIDTH    = 6,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           fill_valid_i,
  output logic                           fill_ready_o,
  input  logic [ADDR_WIDTH+DATA_WIDTH-1:0] fill_data_i,
  input  logic                           refill_valid_i,
  output logic                           refill_ready_o,
  input  logic [ADDR_WIDTH+DATA_WIDTH-1:0] refill_data_i,
  output logic [ID_WIDTH-1:0]            awid_o,
  output logic [ADDR_WIDTH-1:0]          awaddr_o,
  output logic                           awvalid_o,
  input  logic                           awready_i,
  output logic [TAG_SIZE+DATA_WIDTH-1:0] wdata_o,
  output logic                           wvalid_o,
  output logic                           wlast_o,
  input  logic                           wready_i,
  input  logic [ID_WIDTH-1:0]            bid_i,
  input  logic [1:0]                     bresp_i,
  input  logic                           bvalid_i,
  output logic                           bready_o,
  output logic                           err_o
`ifdef FILL_ARB_STAT_EN
  ,
  output logic [31:0]                    fill_cnt_o,
  output logic [31:0]                    refill_cnt_o,
  output logic [31:0]                    stall_cnt_o
`endif
);

  localparam int LINE_W    = ADDR_WIDTH + DATA_WIDTH;
  localparam int CNT_W     = $clog2(MAX_OUTSTANDING + 1);
  localparam int VALID_BIT = meta_valid_bit(TAG_SIZE);
  localparam int DIRTY_BIT = meta_dirty_bit(TAG_SIZE);
  localparam int TAG_LSB   = meta_tag_lsb(TAG_SIZE, TAG_WIDTH);

  fill_state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic awvalid_q, awvalid_d;
  logic wvalid_q, wvalid_d;
  logic err_q, err_d;
  logic [ID_WIDTH-1:0] awid_q, awid_d;
  logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
  logic [TAG_SIZE+DATA_WIDTH-1:0] wdata_q, wdata_d;

  logic [1:0] gnt;
  logic room, idle, accept;
  logic aw_hs, aw_done, w_done;
  logic [LINE_W-1:0] sel_line;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [TAG_SIZE-1:0] meta;
  logic unused_bid;

  assign unused_bid = ^bid_i;

  fill_rr_arb u_arb (
    .clk      (clk),
    .rst      (rst),
    .req_i    ({refill_valid_i, fill_valid_i}),
    .accept_i (accept),
    .gnt_o    (gnt)
  );

  assign room           = cnt_q < CNT_W'(MAX_OUTSTANDING);
  assign idle           = state_q == S_IDLE;
  assign fill_ready_o   = idle & gnt[0] & room;
  assign refill_ready_o = idle & gnt[1] & room;
  assign accept = (fill_valid_i & fill_ready_o)
                | (refill_valid_i & refill_ready_o);

  assign aw_hs   = awvalid_q & awready_i;
  assign aw_done = ~awvalid_q | awready_i;
  assign w_done  = ~wvalid_q | wready_i;

  assign sel_line = gnt[1] ? refill_data_i : fill_data_i;
  assign sel_addr = sel_line[LINE_W-1 -: ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (accept) state_d = S_ISSUE;
      S_ISSUE: if (aw_done & w_done) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    meta            = '0;
    meta[VALID_BIT] = 1'b1;
    meta[DIRTY_BIT] = gnt[0];
    meta[TAG_LSB +: TAG_WIDTH] =
      TAG_WIDTH'(sel_addr >> (INDEX_WIDTH + OFFSET_WIDTH));
  end

  // Payload regs only load on accept so they stay stable under valid.
  always_comb begin
    awvalid_d = awvalid_q & ~awready_i;
    wvalid_d  = wvalid_q & ~wready_i;
    awid_d    = awid_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    if (accept) begin
      awvalid_d = 1'b1;
      wvalid_d  = 1'b1;
      awid_d    = ID_WIDTH'(gnt[1]);
      awaddr_d  = sel_addr;
      awaddr_d[OFFSET_WIDTH-1:0] = '0;
      wdata_d   = {meta, sel_line[DATA_WIDTH-1:0]};
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    case ({aw_hs, bvalid_i})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
    err_d = err_q
          | (bvalid_i & ((bresp_i != 2'b00) | (cnt_q == '0)));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      err_q     <= 1'b0;
      awid_q    <= '0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
    end else begin
      cnt_q     <= cnt_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      err_q     <= err_d;
      awid_q    <= awid_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
    end
  end

  assign awvalid_o = awvalid_q;
  assign wvalid_o  = wvalid_q;
  assign wlast_o   = wvalid_q;
  assign awid_o    = awid_q;
  assign awaddr_o  = awaddr_q;
  assign wdata_o   = wdata_q;
  assign bready_o  = 1'b1;
  assign err_o     = err_q;

`ifdef FILL_ARB_STAT_EN
  logic [31:0] fill_cnt_q, fill_cnt_d;
  logic [31:0] refill_cnt_q, refill_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    fill_cnt_d   = fill_cnt_q;
    refill_cnt_d = refill_cnt_q;
    stall_cnt_d  = stall_cnt_q;
    if (fill_valid_i & fill_ready_o)     fill_cnt_d   = fill_cnt_q + 32'd1;
    if (refill_valid_i & refill_ready_o) refill_cnt_d = refill_cnt_q + 32'd1;
    if ((fill_valid_i | refill_valid_i) & ~room)
      stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fill_cnt_q   <= '0;
      refill_cnt_q <= '0;
      stall_cnt_q  <= '0;
    end else begin
      fill_cnt_q   <= fill_cnt_d;
      refill_cnt_q <= refill_cnt_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  assign fill_cnt_o   = fill_cnt_q;
  assign refill_cnt_o = refill_cnt_q;
  assign stall_cnt_o  = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fill_arbiter.sv
// Scoreboard bench for fill_arbiter with directed vectors.
module tb_fill_arbiter;

  localparam logic [511:0] D0 = {16{32'hA5A5_0001}};
  localparam logic [511:0] D1 = {16{32'h5A5A_0002}};
  localparam logic [31:0] A0 = 32'h0001_2340;
  localparam logic [31:0] A1 = 32'h8765_43FF;
  localparam logic [31:0] A1_LINE = 32'h8765_43C0;
  localparam logic [31:0] M0 = 32'hC000_4000;
  localparam logic [31:0] M1 = 32'hA1D9_4000;

  typedef struct {
    logic [3:0]  id;
    logic [31:0] addr;
  } aw_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic fill_valid = 1'b0;
  logic refill_valid = 1'b0;
  logic [543:0] fill_data = '0;
  logic [543:0] refill_data = '0;
  logic awready = 1'b1;
  logic wready = 1'b1;
  logic [3:0] bid = '0;
  logic [1:0] bresp = '0;
  logic b_man = 1'b0;
  logic b_auto = 1'b0;
  logic auto_b = 1'b0;
  logic hs_seen = 1'b0;
  logic bvalid;

  logic fill_ready, refill_ready;
  logic [3:0] awid;
  logic [31:0] awaddr;
  logic awvalid, wvalid, wlast, bready, err;
  logic [543:0] wdata;

  aw_t awq[$];
  logic [543:0] wq[$];

  int cmp = 0;
  int bad = 0;
  int mcmp = 0;
  int mbad = 0;

  assign bvalid = auto_b ? b_auto : b_man;

  always #5 clk = ~clk;

  fill_arbiter #(.MAX_OUTSTANDING(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .fill_valid_i   (fill_valid),
    .fill_ready_o   (fill_ready),
    .fill_data_i    (fill_data),
    .refill_valid_i (refill_valid),
    .refill_ready_o (refill_ready),
    .refill_data_i  (refill_data),
    .awid_o         (awid),
    .awaddr_o       (awaddr),
    .awvalid_o      (awvalid),
    .awready_i      (awready),
    .wdata_o        (wdata),
    .wvalid_o       (wvalid),
    .wlast_o        (wlast),
    .wready_i       (wready),
    .bid_i          (bid),
    .bresp_i        (bresp),
    .bvalid_i       (bvalid),
    .bready_o       (bready),
    .err_o          (err)
  );

  // Monitor: pops expected beats on each AW/W handshake.
  initial begin
    forever begin
      @(negedge clk);
      hs_seen = awvalid & awready & ~rst;
      if (!rst) begin
        mcmp++;
        if (fill_ready & refill_ready) begin
          mbad++;
          $display("FAIL ready_excl: got both ready want one");
        end
        mcmp++;
        if (wlast !== wvalid) begin
          mbad++;
          $display("FAIL wlast: got %0b want %0b", wlast, wvalid);
        end
        if (awvalid & awready) begin
          mcmp++;
          if (awq.size() == 0) begin
            mbad++;
            $display("FAIL aw_unexp: got addr %0h want none", awaddr);
          end else begin
            aw_t e;
            e = awq.pop_front();
            if (awid !== e.id || awaddr !== e.addr) begin
              mbad++;
              $display("FAIL aw_beat: got id %0h addr %0h want id %0h addr %0h",
                       awid, awaddr, e.id, e.addr);
            end
          end
        end
        if (wvalid & wready) begin
          mcmp++;
          if (wq.size() == 0) begin
            mbad++;
            $display("FAIL w_unexp: got meta %0h want none", wdata[543:512]);
          end else begin
            logic [543:0] ew;
            ew = wq.pop_front();
            if (wdata !== ew) begin
              mbad++;
              $display("FAIL w_beat: got %0h want %0h", wdata, ew);
            end
          end
        end
      end
    end
  end

  // Auto B responder: one response the cycle after each AW handshake.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      b_auto = auto_b & hs_seen;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic nedge;
    @(negedge clk);
  endtask

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    cmp++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic do_reset;
    rst = 1'b1;
    fill_valid = 1'b0;
    refill_valid = 1'b0;
    b_man = 1'b0;
    bresp = 2'b00;
    awready = 1'b1;
    wready = 1'b1;
    auto_b = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic exp_fill;
    awq.push_back('{id: 4'd0, addr: A0});
    wq.push_back({M0, D0});
  endtask

  task automatic exp_refill;
    awq.push_back('{id: 4'd1, addr: A1_LINE});
    wq.push_back({M1, D1});
  endtask

  initial begin
    fill_data = {A0, D0};
    refill_data = {A1, D1};

    // Reset state and a single port-0 fill
    do_reset();
    nedge();
    chk("rst_awvalid", awvalid, 0);
    chk("rst_wvalid", wvalid, 0);
    chk("rst_wlast", wlast, 0);
    chk("rst_err", err, 0);
    chk("rst_bready", bready, 1);
    chk("rst_awid", awid, 0);
    chk("rst_awaddr", awaddr, 0);
    chk("rst_wdata", |wdata, 0);
    tick();
    exp_fill();
    fill_valid = 1'b1;
    nedge();
    chk("t1_fill_rdy", fill_ready, 1);
    chk("t1_refill_rdy", refill_ready, 0);
    tick();
    fill_valid = 1'b0;
    nedge();
    chk("t1_awvalid", awvalid, 1);
    chk("t1_wvalid", wvalid, 1);
    tick();
    nedge();
    chk("t1_aw_drop", awvalid, 0);
    chk("t1_w_drop", wvalid, 0);
    tick();

    // Both ports continuously valid: 0,1,0,1 every 2 cycles
    do_reset();
    auto_b = 1'b1;
    exp_fill();
    exp_refill();
    exp_fill();
    exp_refill();
    fill_valid = 1'b1;
    refill_valid = 1'b1;
    for (int k = 0; k < 8; k++) begin
      nedge();
      chk($sformatf("t2_fill_rdy%0d", k), fill_ready, (k % 4) == 0);
      chk($sformatf("t2_refill_rdy%0d", k), refill_ready, (k % 4) == 2);
      tick();
    end
    fill_valid = 1'b0;
    refill_valid = 1'b0;
    repeat (3) tick();
    auto_b = 1'b0;
    repeat (2) tick();
    nedge();
    chk("t2_err", err, 0);
    tick();

    // AW delayed three cycles, W immediate
    do_reset();
    awready = 1'b0;
    exp_fill();
    fill_valid = 1'b1;
    nedge();
    chk("t3_rdy", fill_ready, 1);
    tick();
    fill_valid = 1'b0;
    nedge();
    chk("t3_awvalid", awvalid, 1);
    chk("t3_wvalid", wvalid, 1);
    tick();
    nedge();
    chk("t3_aw_hold1", awvalid, 1);
    chk("t3_w_drop", wvalid, 0);
    chk("t3_busy1", fill_ready | refill_ready, 0);
    tick();
    nedge();
    chk("t3_aw_hold2", awvalid, 1);
    chk("t3_busy2", fill_ready | refill_ready, 0);
    tick();
    awready = 1'b1;
    nedge();
    chk("t3_aw_hold3", awvalid, 1);
    chk("t3_busy3", fill_ready | refill_ready, 0);
    tick();
    exp_fill();
    fill_valid = 1'b1;
    nedge();
    chk("t3_idle_rdy", fill_ready, 1);
    tick();
    fill_valid = 1'b0;
    repeat (2) tick();

    // Outstanding limit of 2 with manual B responses
    do_reset();
    exp_fill();
    exp_fill();
    fill_valid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      nedge();
      chk($sformatf("t4_rdy%0d", k), fill_ready, k == 0 || k == 2);
      tick();
    end
    b_man = 1'b1;
    nedge();
    chk("t4_stall_b", fill_ready, 0);
    tick();
    b_man = 1'b0;
    exp_fill();
    nedge();
    chk("t4_rearm", fill_ready, 1);
    tick();
    b_man = 1'b1;
    nedge();
    chk("t4_coinc_aw", awvalid & awready, 1);
    tick();
    b_man = 1'b0;
    exp_fill();
    nedge();
    chk("t4_cnt_same", fill_ready, 1);
    tick();
    nedge();
    tick();
    nedge();
    chk("t4_full_again", fill_ready, 0);
    chk("t4_err", err, 0);
    tick();
    fill_valid = 1'b0;

    // Error flag: underflow, clean B, bad bresp
    do_reset();
    nedge();
    chk("t5_err_init", err, 0);
    tick();
    b_man = 1'b1;
    tick();
    b_man = 1'b0;
    nedge();
    chk("t5_underflow", err, 1);
    tick();
    repeat (3) tick();
    nedge();
    chk("t5_sticky1", err, 1);
    tick();
    do_reset();
    nedge();
    chk("t5_err_clr", err, 0);
    tick();
    exp_fill();
    fill_valid = 1'b1;
    tick();
    fill_valid = 1'b0;
    tick();
    b_man = 1'b1;
    tick();
    b_man = 1'b0;
    nedge();
    chk("t5_ok_b", err, 0);
    tick();
    exp_fill();
    fill_valid = 1'b1;
    tick();
    fill_valid = 1'b0;
    tick();
    b_man = 1'b1;
    bresp = 2'b10;
    tick();
    b_man = 1'b0;
    bresp = 2'b00;
    nedge();
    chk("t5_bresp", err, 1);
    tick();
    repeat (2) tick();
    nedge();
    chk("t5_sticky2", err, 1);
    tick();

    // Reset while a burst is pending
    do_reset();
    exp_fill();
    fill_valid = 1'b1;
    tick();
    fill_valid = 1'b0;
    repeat (2) tick();
    awready = 1'b0;
    wready = 1'b0;
    fill_valid = 1'b1;
    tick();
    fill_valid = 1'b0;
    nedge();
    chk("t6_aw_before", awvalid, 1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    nedge();
    chk("t6_awvalid", awvalid, 0);
    chk("t6_wvalid", wvalid, 0);
    chk("t6_bready", bready, 1);
    chk("t6_awaddr", awaddr, 0);
    chk("t6_awid", awid, 0);
    chk("t6_wdata", |wdata, 0);
    chk("t6_err", err, 0);
    tick();
    awready = 1'b1;
    wready = 1'b1;
    b_man = 1'b1;
    tick();
    b_man = 1'b0;
    nedge();
    chk("t6_cnt_zero", err, 1);
    tick();

    nedge();
    chk("aw_queue_empty", awq.size(), 0);
    chk("w_queue_empty", wq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             cmp + mcmp, bad + mbad);
    $finish;
  end

endmodule
